// File: rtl/lsfr_pkg.sv
// Shared definitions for the LFSR generator/checker pair: default tap masks,
// the Fibonacci next-state function and the checker FSM state encoding.
package lsfr_pkg;

  typedef enum logic [1:0] {
    LSFR_HUNT   = 2'd0,
    LSFR_SYNC   = 2'd1,
    LSFR_LOCKED = 2'd2
  } lsfr_chk_state_t;

  // Maximal-length feedback masks; bit (n-1) is the x^n term.
  function automatic logic [31:0] lsfr_default_taps(input int data);
    logic [31:0] taps;
    case (data)
      3:       taps = 32'h0000_0006;
      4:       taps = 32'h0000_000C;
      5:       taps = 32'h0000_0014;
      6:       taps = 32'h0000_0030;
      7:       taps = 32'h0000_0060;
      8:       taps = 32'h0000_00B8;
      9:       taps = 32'h0000_0110;
      10:      taps = 32'h0000_0240;
      11:      taps = 32'h0000_0500;
      12:      taps = 32'h0000_0E08;
      13:      taps = 32'h0000_1C80;
      14:      taps = 32'h0000_3802;
      15:      taps = 32'h0000_6000;
      16:      taps = 32'h0000_B400;
      default: taps = 32'h0000_0000;
    endcase
    return taps;
  endfunction

  // Fibonacci step on the low 'width' bits: shift left, feedback enters bit 0.
  function automatic logic [31:0] lsfr_next(input logic [31:0] state,
                                            input logic [31:0] taps,
                                            input int          width);
    logic [31:0] mask;
    logic        fb;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    fb   = ^(state & taps & mask);
    return ((state << 1) | {31'd0, fb}) & mask;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// W-bit up counter that sticks at all-ones; a clear wins over an increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/lsfr_check.sv
// Receive-side PRBS checker: locks onto an lsfr word stream, then flywheels
// its own prediction and flags/counts every word that deviates from it.
module lsfr_check
  import lsfr_pkg::*;
#(
  parameter int              DATA     = 8,
  parameter logic [DATA-1:0] TAPS     = DATA'(lsfr_default_taps(DATA)),
  parameter int              SYNC_LEN = 4,
  parameter int              LOSS_LEN = 4,
  parameter int              CNT      = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [DATA-1:0] in,
  input  logic            clr,
  output logic            locked,
  output logic            err,
  output logic [CNT-1:0]  err_cnt,
  output lsfr_chk_state_t dbg_state
);

  // Handshake: in_valid qualifies in; there is no backpressure, so every
  // cycle with in_valid high consumes exactly one word and idle cycles freeze state.

  localparam int RUN_MAX = (SYNC_LEN > LOSS_LEN) ? SYNC_LEN : LOSS_LEN;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);
  localparam logic [RUN_W-1:0] SYNC_LAST = RUN_W'(SYNC_LEN - 1);
  localparam logic [RUN_W-1:0] LOSS_LAST = RUN_W'(LOSS_LEN - 1);

  lsfr_chk_state_t state_q, state_d;
  logic [DATA-1:0] expect_q, expect_d;
  logic [RUN_W-1:0] match_q, match_d;
  logic [RUN_W-1:0] miss_q, miss_d;
  logic            err_q, err_d;
  logic            locked_q;
  logic            cnt_inc;

  logic [DATA-1:0] nxt_in;
  logic [DATA-1:0] nxt_exp;
  logic            in_zero;
  logic            in_match;

  assign nxt_in   = DATA'(lsfr_next(32'(in), 32'(TAPS), DATA));
  assign nxt_exp  = DATA'(lsfr_next(32'(expect_q), 32'(TAPS), DATA));
  assign in_zero  = (in == '0);
  assign in_match = (in == expect_q);

  // State register and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= LSFR_HUNT;
      expect_q <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      expect_q <= expect_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      err_q    <= err_d;
      locked_q <= (state_d == LSFR_LOCKED);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    expect_d = expect_q;
    match_d  = match_q;
    miss_d   = miss_q;
    if (in_valid) begin
      case (state_q)
        LSFR_HUNT: begin
          // An all-zero word is the LFSR lock-up state and can never seed.
          if (!in_zero) begin
            expect_d = nxt_in;
            match_d  = '0;
            state_d  = LSFR_SYNC;
          end
        end
        LSFR_SYNC: begin
          if (in_match) begin
            expect_d = nxt_in;
            match_d  = match_q + RUN_W'(1);
            if (match_q == SYNC_LAST) begin
              state_d = LSFR_LOCKED;
            end
          end else if (in_zero) begin
            state_d = LSFR_HUNT;
          end else begin
            expect_d = nxt_in;
            match_d  = '0;
          end
        end
        LSFR_LOCKED: begin
          // Flywheel: a corrupted word never disturbs the prediction.
          expect_d = nxt_exp;
          if (in_match) begin
            miss_d = '0;
          end else if (miss_q == LOSS_LAST) begin
            miss_d  = '0;
            state_d = LSFR_HUNT;
          end else begin
            miss_d = miss_q + RUN_W'(1);
          end
        end
        default: begin
          state_d = LSFR_HUNT;
        end
      endcase
    end
  end

  // Error decode: only mismatches seen while locked are reported.
  always_comb begin
    err_d   = 1'b0;
    cnt_inc = 1'b0;
    if (in_valid && (state_q == LSFR_LOCKED) && !in_match) begin
      err_d   = 1'b1;
      cnt_inc = 1'b1;
    end
  end

  sat_counter #(
    .W (CNT)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr   (clr),
    .inc   (cnt_inc),
    .count (err_cnt)
  );

  assign locked    = locked_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lsfr_check.sv
// Directed bench for lsfr_check: a 16-bit-counter instance plus a 3-bit-counter
// instance on the same stream, checked through an expected-response queue.
module tb_lsfr_check;
  import lsfr_pkg::*;

  localparam int EW = 21;  // {locked, err, err_cnt[15:0], err_cnt_s[2:0]}

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic [7:0]      in_w;
  logic            clr;
  logic            locked, err;
  logic [15:0]     err_cnt;
  lsfr_chk_state_t dbg_state;
  logic            locked_s, err_s;
  logic [2:0]      err_cnt_s;
  lsfr_chk_state_t dbg_state_s;

  logic [EW-1:0] exp_q[$];
  logic [15:0]   m_cnt;
  logic [2:0]    m_cnt_s;
  int            errors = 0;
  int            checks = 0;

  // Clock / reset
  always #5 clk = ~clk;

  lsfr_check #(.DATA(8), .SYNC_LEN(4), .LOSS_LEN(4), .CNT(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_w), .clr(clr),
    .locked(locked), .err(err), .err_cnt(err_cnt), .dbg_state(dbg_state)
  );

  lsfr_check #(.DATA(8), .SYNC_LEN(4), .LOSS_LEN(4), .CNT(3)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_w), .clr(clr),
    .locked(locked_s), .err(err_s), .err_cnt(err_cnt_s), .dbg_state(dbg_state_s)
  );

  function automatic logic [7:0] gen_next(input logic [7:0] s);
    return {s[6:0], ^(s & 8'hB8)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Driver tasks: one call covers one clock cycle.
  task automatic drive(input logic v, input logic [7:0] w, input logic lk,
                       input logic er, input logic c);
    in_valid = v;
    in_w     = w;
    clr      = c;
    if (c) begin
      m_cnt   = '0;
      m_cnt_s = '0;
    end else if (er) begin
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (m_cnt_s != 3'h7)   m_cnt_s = m_cnt_s + 3'd1;
    end
    exp_q.push_back({lk, er, m_cnt, m_cnt_s});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic send(input logic [7:0] w, input logic lk, input logic er);
    drive(1'b1, w, lk, er, 1'b0);
  endtask

  task automatic idle(input logic lk);
    drive(1'b0, 8'h00, lk, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_locked",   32'(locked),    32'd0);
    check("rst_err",      32'(err),       32'd0);
    check("rst_err_cnt",  32'(err_cnt),   32'd0);
    check("rst_locked_s", 32'(locked_s),  32'd0);
    check("rst_state",    32'(dbg_state), 32'(LSFR_HUNT));
    m_cnt   = '0;
    m_cnt_s = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Scoreboard monitor: pops the entry for the edge just taken, compares mid-cycle.
  initial begin : monitor
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        @(negedge clk);
        check("locked",    32'(locked),    32'(e[20]));
        check("err",       32'(err),       32'(e[19]));
        check("err_cnt",   32'(err_cnt),   32'(e[18:3]));
        check("locked_s",  32'(locked_s),  32'(e[20]));
        check("err_s",     32'(err_s),     32'(e[19]));
        check("err_cnt_s", 32'(err_cnt_s), 32'(e[2:0]));
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [7:0] s;
    logic [7:0] t;
    logic [7:0] zs [7];
    zs = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h11};

    reset    = 1'b0;
    in_valid = 1'b0;
    in_w     = 8'h00;
    clr      = 1'b0;
    m_cnt    = '0;
    m_cnt_s  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("init_locked",  32'(locked),    32'd0);
    check("init_err",     32'(err),       32'd0);
    check("init_err_cnt", 32'(err_cnt),   32'd0);
    check("init_state",   32'(dbg_state), 32'(LSFR_HUNT));
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Clean generator stream from 01: lock on the 4th word after the seed.
    s = 8'h01;
    for (int i = 0; i < 510; i++) begin
      send(s, (i >= 4), 1'b0);
      if (i == 0) check("seed_state", 32'(dbg_state), 32'(LSFR_SYNC));
      s = gen_next(s);
    end

    // Single corrupted word: one error, lock held, stream still matches.
    send(8'h00, 1'b1, 1'b1);
    s = gen_next(s);
    for (int i = 0; i < 5; i++) begin
      send(s, 1'b1, 1'b0);
      s = gen_next(s);
    end

    // Four consecutive wrong words drop lock on the 4th, then resync.
    for (int k = 0; k < 4; k++) begin
      send(s ^ 8'h5A, (k != 3), 1'b1);
      s = gen_next(s);
    end
    check("loss_state", 32'(dbg_state), 32'(LSFR_HUNT));
    for (int i = 0; i < 7; i++) begin
      send(s, (i >= 4), 1'b0);
      s = gen_next(s);
    end

    // Asynchronous reset while locked.
    pulse_reset();

    // Zeros are ignored in HUNT; seed on 01, lock on 11.
    for (int i = 0; i < 7; i++) begin
      send(zs[i], (i == 6), 1'b0);
      if (i == 1) check("zero_hunt", 32'(dbg_state), 32'(LSFR_HUNT));
    end
    s = 8'h23;
    for (int i = 0; i < 3; i++) begin
      send(s, 1'b1, 1'b0);
      s = gen_next(s);
    end

    // SYNC reseed on a nonzero mismatch: 05 seeds, 0A matches, 33 reseeds.
    pulse_reset();
    send(8'h05, 1'b0, 1'b0);
    send(8'h0A, 1'b0, 1'b0);
    send(8'h33, 1'b0, 1'b0);
    check("reseed_state", 32'(dbg_state), 32'(LSFR_SYNC));
    t = gen_next(8'h33);
    for (int i = 0; i < 4; i++) begin
      send(t, (i == 3), 1'b0);
      t = gen_next(t);
    end

    // SYNC receiving a zero returns to HUNT.
    pulse_reset();
    send(8'h07, 1'b0, 1'b0);
    send(8'h0E, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    check("sync_zero_hunt", 32'(dbg_state), 32'(LSFR_HUNT));

    // Valid toggling every cycle on a correct stream.
    pulse_reset();
    s = 8'h3C;
    for (int i = 0; i < 10; i++) begin
      send(s, (i >= 4), 1'b0);
      idle(i >= 4);
      s = gen_next(s);
    end

    // Nine errors without losing lock: 3-bit instance saturates at 7.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) begin
        send(s ^ 8'hFF, 1'b1, 1'b1);
        s = gen_next(s);
      end
      send(s, 1'b1, 1'b0);
      s = gen_next(s);
    end

    // Clear with a simultaneous error, then clear while idle, then count again.
    drive(1'b1, s ^ 8'hFF, 1'b1, 1'b1, 1'b1);
    s = gen_next(s);
    send(s, 1'b1, 1'b0);
    s = gen_next(s);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    send(s ^ 8'hFF, 1'b1, 1'b1);
    s = gen_next(s);
    send(s, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsfr_check.md
# lsfr_check

Pseudo-random sequence checker: the receive-side counterpart of the `lsfr` generator. It consumes a DATA-bit word stream, self-synchronises to the maximal-length LFSR sequence and flags every word that deviates from the predicted value. It sits at the far end of a datapath under test, with `lsfr` as the stimulus source, and reports lock status and a saturating error count to the bench or a status register.

## Interface
- DATA, 8, word width; also the LFSR length.
- TAPS, 8'hB8, feedback tap mask for DATA=8 (x^8+x^6+x^5+x^4+1). Default comes from the package table.
- SYNC_LEN, 4, consecutive correct words required to declare lock (≥1).
- LOSS_LEN, 4, consecutive wrong words in LOCKED that drop lock (≥1).
- CNT, 16, error counter width.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  qualifies `in`; idle cycles are legal anywhere.
- in  in  DATA  received word.
- clr  in  1  synchronous clear of `err_cnt`.
- locked  out  1  high in LOCKED state.
- err  out  1  one-cycle pulse per mismatching word while LOCKED.
- err_cnt  out  CNT  saturating count of mismatches seen while LOCKED.

## Operation
- Next-state function `lsfr_next(s)` (Fibonacci): fb = ^(s & TAPS); next = {s[DATA-2:0], fb}. It must be bit-identical to `lsfr`. From 8'h01: 01,02,04,08,11,23,47,8E,…
- FSM states: HUNT, SYNC, LOCKED. Internal regs: `expect`, `match_run`, `miss_run`.
- HUNT: on a valid nonzero `in`: expect←lsfr_next(in), match_run←0, go to SYNC. A valid `in`==0 is ignored (lock-up state).
- SYNC, valid word:
  - in==expect: expect←lsfr_next(in), match_run++. Go to LOCKED when match_run==SYNC_LEN-1.
  - Mismatch, nonzero: reseed expect←lsfr_next(in), match_run←0, stay in SYNC.
  - Mismatch, in==0: go to HUNT.
  - No `err` pulses and no count changes in SYNC.
- LOCKED, valid word:
  - expect←lsfr_next(expect) always (flywheel; it never reseeds from `in`), so a single corrupted word costs exactly one error.
  - Match: miss_run←0.
  - Mismatch: err←1, err_cnt saturating increment (stops at 2^CNT-1), miss_run++.
  - When miss_run==LOSS_LEN-1 on a mismatch: go to HUNT, miss_run←0.
- in_valid low: all state holds; err←0.
- clr takes priority over an increment in the same cycle: err_cnt←0, while `err` still pulses.
- The period is 2^DATA-1 words; wrap-around needs no special handling.

## Timing
- Reset values: state=HUNT, locked=0, err=0, err_cnt=0, expect=0, runs=0.
- All outputs are registered. `err`/`err_cnt` update on the clock edge that samples the offending word (visible 1 cycle after the sample).
- `locked` rises on the edge that samples the SYNC_LEN-th consecutive correct word after the seed. It falls on the edge that samples the LOSS_LEN-th consecutive mismatch; that last mismatch still pulses `err` and counts.
- Reset asserted mid-stream: immediate return to reset values. After release, resync from HUNT.

## Structure
- Shared package `lsfr_pkg`: per-DATA default TAPS constants, function `lsfr_next(state, taps)`, and the FSM state enum `lsfr_chk_state_t`. `lsfr` is refactored to use the same function.
- Natural sub-module: `sat_counter` (CNT-bit, inc/clr, saturating). Everything else stays in `lsfr_check`.

## Test plan
- `lsfr` (DATA=8) drives `in` continuously from reset → locked=1 after seed+4 words; over 255·2 words err never pulses; err_cnt=0.
- Lock, then replace one word (e.g. 47→00) → exactly one `err` pulse, err_cnt=1, locked stays 1, following words match.
- Lock, then feed 4 consecutive wrong words → err_cnt=4, locked falls on the 4th; the generator stream resumes → relock after 5 valid words.
- Stream 00,00,01,02,04,08,11 → stays in HUNT through the zeros, seeds on 01, locked=1 after 11.
- in_valid toggling 1/0 every cycle with a correct stream → lock and zero errors; counter values at err_cnt=16'hFFFE plus 3 errors → saturate at FFFF; clr together with an error → err_cnt=0, err=1.
- reset pulsed low while LOCKED mid-stream → outputs 0 asynchronously; relock after release with err_cnt=0.
